approx_dot_accumulator: RTL and testbench
=========================================

# approx_dot_accumulator

Sequential accumulator directly downstream of the approximate unsigned integer multiplier. It consumes a stream of unsigned product magnitudes, each with a sign bit from the sign-magnitude wrapper, and sums them into a signed, saturating accumulator. When the beat marked last arrives it emits one dot-product result through a valid/ready output register. It is the reduction stage of the approximate MAC datapath, turning per-element products into per-vector results.

## Interface
- WIDTH, 8: operand width of the upstream multiplier; product magnitude is 2*WIDTH bits.
- ACC_WIDTH, 32: signed accumulator/result width; must be >= 2*WIDTH+1.
- CNT_WIDTH, 8: beat-counter width.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- prod  input  2*WIDTH  unsigned product magnitude (multiplier R output).
- prod_neg  input  1  1 = product is negative (sign of A XOR sign of B).
- prod_last  input  1  marks final beat of a vector.
- prod_valid  input  1  upstream beat valid.
- prod_ready  output  1  this block accepts a beat this cycle.
- out_data  output  ACC_WIDTH  signed two's-complement dot-product result.
- out_sat  output  1  1 = saturation occurred somewhere in this vector.
- out_count  output  CNT_WIDTH  number of beats in this vector; saturates at all-ones.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.

## Operation
- A beat is accepted when prod_valid && prod_ready.
- prod_ready = ~out_valid | out_ready. This is combinational from out_ready; all other outputs are registered.
- Signed term: +prod if prod_neg=0, otherwise -prod, sign-extended to ACC_WIDTH+1. prod=0 with prod_neg=1 gives 0.
- Base value: 0 on the first beat of a vector (internal first flag = 1), otherwise the accumulator register.
- Sum is computed at ACC_WIDTH+1 bits.
  - If the sum is above 2^(ACC_WIDTH-1)-1, clamp to that value and flag saturation for this beat.
  - If the sum is below -2^(ACC_WIDTH-1), clamp to that value and flag saturation for this beat.
- Accepted non-last beat:
  - acc <= clamped sum.
  - sticky_sat <= sticky_sat | sat_now.
  - count <= count+1, saturating at all-ones.
  - first <= 0.
- Accepted last beat:
  - out_data <= clamped sum.
  - out_sat <= sticky_sat | sat_now.
  - out_count <= count+1, saturating.
  - out_valid <= 1.
  - acc, sticky_sat and count cleared; first <= 1.
- A vector of length 1 is allowed: first and last on the same beat.
- Output handshake:
  - out_valid, out_data, out_sat and out_count hold stable until out_valid && out_ready.
  - On a handshake with no new last beat, out_valid <= 0. Data registers keep their values.
  - If the output handshake and a last-beat accept happen in the same cycle, out_valid stays 1 and the registers load the new result. No bubble.
- While out_valid=1 and out_ready=0, prod_ready=0. No beat is accepted, including non-last beats, and the accumulator is frozen.
- prod, prod_neg and prod_last are ignored when not accepted.

## Timing
- Reset (async assert, sync-safe deassert into the first clk edge):
  - out_valid=0, out_data=0, out_sat=0, out_count=0.
  - acc=0, sticky_sat=0, count=0, first=1.
- Latency: a last beat accepted at edge N gives out_valid=1 with the result after edge N, so it is visible in cycle N+1.
- Throughput: one beat per cycle while downstream keeps out_ready=1 or the output is empty.
- Reset mid-vector discards the partial sum. The next accepted beat starts a new vector.
- out_count wraps never: it saturates at 2^CNT_WIDTH-1. The accumulated value is still exact up to saturation.

## Test plan
- Basic vector (WIDTH=8, ACC_WIDTH=32): products 100(+), 50(-), 7(+), last on the 3rd beat, out_ready=1 -> out_data=57, out_sat=0, out_count=3, one cycle after the last beat.
- Single-beat vector: prod=65025, prod_neg=1, last=1 -> out_data=-65025, out_count=1. The next vector 10(+) last -> 10, showing the accumulator was cleared.
- Saturation (ACC_WIDTH=18): 3 beats of 65025(+), last on the 3rd -> out_data=131071, out_sat=1, out_count=3. A following vector 1(+) last -> out_sat=0.
- Backpressure: result pending with out_ready=0 for 5 cycles -> prod_ready=0, and out_data, out_sat and out_count stay stable. Then drive out_ready=1 and a last beat in the same cycle -> the new result loads with out_valid held at 1 and no bubble.
- Async reset: assert rst_n=0 after 2 beats of a 4-beat vector -> all outputs 0 immediately. After release, a 1-beat vector of 5(+) -> out_data=5, out_count=1.
- Random stream of 1000 vectors, lengths 1-20, random valid/ready gaps -> results match a saturating reference model, with no beat lost or duplicated.

Source files
------------

// File: rtl/approx_dot_accumulator_if.sv
// Beat-in / result-out bundle of the approximate dot-product accumulator.
interface approx_dot_accumulator_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 8
);
    logic [2*WIDTH-1:0]   prod;
    logic                 prod_neg;
    logic                 prod_last;
    logic                 prod_valid;
    logic                 prod_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 out_sat;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_valid;
    logic                 out_ready;

    // Product source and result sink side.
    modport master (
        output prod, prod_neg, prod_last, prod_valid, out_ready,
        input  prod_ready, out_data, out_sat, out_count, out_valid
    );

    // Accumulator side.
    modport slave (
        input  prod, prod_neg, prod_last, prod_valid, out_ready,
        output prod_ready, out_data, out_sat, out_count, out_valid
    );
endinterface

// File: rtl/approx_dot_accumulator.sv
// Saturating signed reduction of sign-magnitude products into one result per vector.
module approx_dot_accumulator #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    approx_dot_accumulator_if.slave bus
);
    localparam int unsigned SUM_W = ACC_WIDTH + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // The sum of two in-range terms must fit SUM_W bits for the overflow test to hold.
    if (ACC_WIDTH < 2 * WIDTH + 1) begin : g_bad_acc_width
        $error("ACC_WIDTH must be at least 2*WIDTH+1");
    end

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 first_q, first_d;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_sat_q, out_sat_d;
    logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
    logic                 out_valid_q, out_valid_d;

    logic                 ready_c;
    logic                 accept_c;
    logic [SUM_W-1:0]     term_c;
    logic [SUM_W-1:0]     base_c;
    logic [SUM_W-1:0]     sum_c;
    logic                 pos_ovf_c;
    logic                 neg_ovf_c;
    logic                 sat_now_c;
    logic [ACC_WIDTH-1:0] clamped_c;
    logic [CNT_WIDTH-1:0] cnt_inc_c;

    // Input ready follows the output slot: free, or being drained this cycle.
    always_comb begin
        ready_c  = ~out_valid_q | bus.out_ready;
        accept_c = bus.prod_valid & ready_c;
    end

    // Signed add of the current term onto the running sum, clamped to ACC_WIDTH.
    always_comb begin
        term_c    = bus.prod_neg ? (SUM_W'(0) - SUM_W'(bus.prod)) : SUM_W'(bus.prod);
        base_c    = first_q ? '0 : {acc_q[ACC_WIDTH-1], acc_q};
        sum_c     = base_c + term_c;
        pos_ovf_c = ~sum_c[SUM_W-1] &  sum_c[SUM_W-2];
        neg_ovf_c =  sum_c[SUM_W-1] & ~sum_c[SUM_W-2];
        sat_now_c = pos_ovf_c | neg_ovf_c;
        if (pos_ovf_c) begin
            clamped_c = ACC_MAX;
        end else if (neg_ovf_c) begin
            clamped_c = ACC_MIN;
        end else begin
            clamped_c = sum_c[ACC_WIDTH-1:0];
        end
        cnt_inc_c = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_WIDTH'(1);
    end

    // Next state: accumulate non-last beats, publish on the last beat, drain on handshake.
    always_comb begin
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q & ~bus.out_ready;
        if (accept_c) begin
            if (bus.prod_last) begin
                out_data_d  = clamped_c;
                out_sat_d   = sticky_q | sat_now_c;
                out_count_d = cnt_inc_c;
                out_valid_d = 1'b1;
                acc_d       = '0;
                sticky_d    = 1'b0;
                cnt_d       = '0;
                first_d     = 1'b1;
            end else begin
                acc_d       = clamped_c;
                sticky_d    = sticky_q | sat_now_c;
                cnt_d       = cnt_inc_c;
                first_d     = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
            first_q     <= 1'b1;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.prod_ready = ready_c;
    assign bus.out_data   = out_data_q;
    assign bus.out_sat    = out_sat_q;
    assign bus.out_count  = out_count_q;
    assign bus.out_valid  = out_valid_q;
endmodule

// File: tb/tb_approx_dot_accumulator.sv
// Bench for approx_dot_accumulator: two instances (32-bit/8-bit count and 18-bit/4-bit count)
// share one stimulus stream; results are checked against a saturating vector model.
module tb_approx_dot_accumulator;
    typedef struct packed {
        logic [15:0] p;
        logic        n;
    } beat_t;

    typedef struct {
        longint d32; bit s32; int c32;
        longint d18; bit s18; int c18;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] d_prod = '0;
    logic        d_neg = 1'b0;
    logic        d_last = 1'b0;
    logic        d_valid = 1'b0;
    logic        d_ready = 1'b1;

    int checks = 0;
    int failures = 0;
    int lasts_accepted = 0;
    int consumed = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by directed test
    exp_t exp_q[$];

    always #5 clk = ~clk;

    approx_dot_accumulator_if #(.WIDTH(8), .ACC_WIDTH(32), .CNT_WIDTH(8)) bus32 ();
    approx_dot_accumulator_if #(.WIDTH(8), .ACC_WIDTH(18), .CNT_WIDTH(4)) bus18 ();

    assign bus32.prod       = d_prod;
    assign bus32.prod_neg   = d_neg;
    assign bus32.prod_last  = d_last;
    assign bus32.prod_valid = d_valid;
    assign bus32.out_ready  = d_ready;
    assign bus18.prod       = d_prod;
    assign bus18.prod_neg   = d_neg;
    assign bus18.prod_last  = d_last;
    assign bus18.prod_valid = d_valid;
    assign bus18.out_ready  = d_ready;

    approx_dot_accumulator #(.WIDTH(8), .ACC_WIDTH(32), .CNT_WIDTH(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(bus32));
    approx_dot_accumulator #(.WIDTH(8), .ACC_WIDTH(18), .CNT_WIDTH(4)) dut18 (
        .clk(clk), .rst_n(rst_n), .bus(bus18));

    task automatic check(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic stop_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s timeout at %0t", nm, $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench stopped on timeout");
    endtask

    function automatic beat_t mk(input int p, input bit n);
        beat_t b;
        b.p = 16'(p);
        b.n = n;
        return b;
    endfunction

    // Reference: plain signed sum with per-beat clamping and a saturating length.
    function automatic void model_vec(input beat_t v[$], input int aw, input int cw,
                                      output longint d, output bit s, output int c);
        longint mx, mn, acc;
        int cmax;
        mx = (longint'(1) << (aw - 1)) - 1;
        mn = -(longint'(1) << (aw - 1));
        cmax = (1 << cw) - 1;
        acc = 0;
        s = 1'b0;
        foreach (v[i]) begin
            acc = acc + (v[i].n ? -longint'(v[i].p) : longint'(v[i].p));
            if (acc > mx) begin acc = mx; s = 1'b1; end
            else if (acc < mn) begin acc = mn; s = 1'b1; end
        end
        d = acc;
        c = (v.size() > cmax) ? cmax : v.size();
    endfunction

    task automatic push_exp(input beat_t v[$]);
        exp_t e;
        longint d; bit s; int c;
        model_vec(v, 32, 8, d, s, c);
        e.d32 = d; e.s32 = s; e.c32 = c;
        model_vec(v, 18, 4, d, s, c);
        e.d18 = d; e.s18 = s; e.c18 = c;
        exp_q.push_back(e);
    endtask

    // Present each beat until accepted; returns #1 after the edge that took the final beat.
    task automatic send_beats(input beat_t v[$], input bit push, input bit mark_last,
                              input int gap_pct);
        int waited;
        bit acc;
        if (push) push_exp(v);
        foreach (v[i]) begin
            waited = 0;
            acc = 1'b0;
            while (!acc) begin
                if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                    d_valid = 1'b0;
                    d_prod  = 16'($urandom);
                    d_neg   = 1'($urandom);
                    d_last  = 1'($urandom);
                end else begin
                    d_valid = 1'b1;
                    d_prod  = v[i].p;
                    d_neg   = v[i].n;
                    d_last  = mark_last && (i == v.size() - 1);
                end
                @(negedge clk);
                acc = d_valid && bus32.prod_ready;
                @(posedge clk);
                #1;
                if (acc && d_last) lasts_accepted++;
                waited++;
                if (waited > 1000) stop_now("beat_accept");
            end
        end
        d_valid = 1'b0;
        d_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (consumed != lasts_accepted) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 1000) stop_now("drain");
        end
    endtask

    // Output-ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) d_ready = 1'b1;
            else if (rdy_mode == 1) d_ready = ($urandom_range(99) < 70);
        end
    end

    // Per-cycle comparison of both instances against the model queue.
    always @(negedge clk) begin
        bit ev;
        if (rst_n) begin
            ev = (lasts_accepted > consumed);
            check("out_valid32", longint'(bus32.out_valid), longint'(ev));
            check("out_valid18", longint'(bus18.out_valid), longint'(ev));
            check("prod_ready32", longint'(bus32.prod_ready), longint'(!ev || d_ready));
            check("prod_ready18", longint'(bus18.prod_ready), longint'(!ev || d_ready));
            if (ev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL result_without_vector actual=valid expected=none at %0t", $time);
                end else begin
                    check("out_data32", longint'($signed(bus32.out_data)), exp_q[0].d32);
                    check("out_sat32", longint'(bus32.out_sat), longint'(exp_q[0].s32));
                    check("out_count32", longint'(bus32.out_count), longint'(exp_q[0].c32));
                    check("out_data18", longint'($signed(bus18.out_data)), exp_q[0].d18);
                    check("out_sat18", longint'(bus18.out_sat), longint'(exp_q[0].s18));
                    check("out_count18", longint'(bus18.out_count), longint'(exp_q[0].c18));
                    if (d_ready) begin
                        void'(exp_q.pop_front());
                        consumed++;
                    end
                end
            end
        end
    end

    initial begin
        #(5_000_000);
        stop_now("watchdog");
    end

    initial begin
        beat_t v[$];
        longint md; bit ms; int mc;

        // Hand-computed values pinning the reference model.
        v = {mk(100, 0), mk(50, 1), mk(7, 0)};
        model_vec(v, 32, 8, md, ms, mc);
        check("model_basic_data", md, 57);
        check("model_basic_count", longint'(mc), 3);
        v = {mk(65025, 0), mk(65025, 0), mk(65025, 0)};
        model_vec(v, 18, 4, md, ms, mc);
        check("model_sat_data", md, 131071);
        check("model_sat_flag", longint'(ms), 1);
        v = {};
        for (int i = 0; i < 20; i++) v.push_back(mk(1, 0));
        model_vec(v, 18, 4, md, ms, mc);
        check("model_count_clamp", longint'(mc), 15);

        // Reset state.
        #1 rst_n = 1'b0;
        #12;
        check("rst_out_valid", longint'(bus32.out_valid), 0);
        check("rst_out_data", longint'(bus32.out_data), 0);
        check("rst_out_sat", longint'(bus32.out_sat), 0);
        check("rst_out_count", longint'(bus32.out_count), 0);
        check("rst_prod_ready", longint'(bus32.prod_ready), 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic three-beat vector, result one cycle after the last beat.
        send_beats({mk(100, 0), mk(50, 1), mk(7, 0)}, 1, 1, 0);
        check("basic_valid", longint'(bus32.out_valid), 1);
        check("basic_data", longint'($signed(bus32.out_data)), 57);
        check("basic_sat", longint'(bus32.out_sat), 0);
        check("basic_count", longint'(bus32.out_count), 3);

        // Single-beat vectors; accumulator cleared between them.
        send_beats({mk(65025, 1)}, 1, 1, 0);
        check("single_neg_data", longint'($signed(bus32.out_data)), -65025);
        check("single_neg_count", longint'(bus32.out_count), 1);
        send_beats({mk(10, 0)}, 1, 1, 0);
        check("single_pos_data", longint'($signed(bus32.out_data)), 10);

        // Saturation on the 18-bit instance, then a clean vector.
        send_beats({mk(65025, 0), mk(65025, 0), mk(65025, 0)}, 1, 1, 0);
        check("sat18_data", longint'($signed(bus18.out_data)), 131071);
        check("sat18_flag", longint'(bus18.out_sat), 1);
        check("sat18_count", longint'(bus18.out_count), 3);
        check("nosat32_data", longint'($signed(bus32.out_data)), 195075);
        send_beats({mk(1, 0)}, 1, 1, 0);
        check("after_sat18_flag", longint'(bus18.out_sat), 0);
        check("after_sat18_data", longint'($signed(bus18.out_data)), 1);

        // Backpressure: held result, then same-cycle drain and reload.
        wait_drain();
        rdy_mode = 2;
        d_ready = 1'b0;
        send_beats({mk(3, 0)}, 1, 1, 0);
        push_exp({mk(9, 0)});
        d_valid = 1'b1;
        d_prod  = 16'd9;
        d_neg   = 1'b0;
        d_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_prod_ready", longint'(bus32.prod_ready), 0);
            check("bp_hold_data", longint'($signed(bus32.out_data)), 3);
            check("bp_hold_count", longint'(bus32.out_count), 1);
            check("bp_hold_valid", longint'(bus32.out_valid), 1);
        end
        @(posedge clk);
        #1 d_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", longint'(bus32.prod_ready), 1);
        @(posedge clk);
        #1;
        lasts_accepted++;
        d_valid = 1'b0;
        d_last  = 1'b0;
        check("bp_nobubble_valid", longint'(bus32.out_valid), 1);
        check("bp_new_data", longint'($signed(bus32.out_data)), 9);
        rdy_mode = 0;
        wait_drain();

        // Asynchronous reset in the middle of a vector.
        send_beats({mk(40, 0), mk(2, 1)}, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", longint'(bus32.out_valid), 0);
        check("arst_data", longint'(bus32.out_data), 0);
        check("arst_count", longint'(bus32.out_count), 0);
        check("arst_count18", longint'(bus18.out_count), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_beats({mk(5, 0)}, 1, 1, 0);
        check("post_rst_data", longint'($signed(bus32.out_data)), 5);
        check("post_rst_count", longint'(bus32.out_count), 1);

        // Random vectors with input gaps and output backpressure.
        rdy_mode = 1;
        for (int k = 0; k < 1000; k++) begin
            int len;
            int cls;
            int p;
            len = $urandom_range(20, 1);
            v = {};
            for (int j = 0; j < len; j++) begin
                cls = $urandom_range(9);
                if (cls == 0) p = 0;
                else if (cls < 5) p = $urandom_range(255);
                else p = $urandom_range(65535);
                v.push_back(mk(p, 1'($urandom)));
            end
            send_beats(v, 1, 1, 25);
        end
        rdy_mode = 0;
        wait_drain();
        @(posedge clk);
        #1;
        check("queue_empty", longint'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
